reg_cmd_parser: RTL and testbench
=================================

REG_CMD_PARSER -- requirements
Module: reg_cmd_parser

Interface
REQ-001 The parameter NUM_REGS SHALL default to 4 and set the number of 8-bit control registers (legal range 1..256).
REQ-002 The parameter TIMEOUT_CYCLES SHALL default to 1000000 and set the maximum idle clock cycles between bytes of one command.
REQ-003 The parameter RESET_VAL SHALL default to 8'h00 and set the reset value of every register.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 rx_byte  in  8  received byte, valid when rx_dv=1.
REQ-007 rx_dv  in  1  one-cycle strobe per received byte.
REQ-008 tx_done  in  1  one-cycle strobe when the transmitter finishes a byte.
REQ-009 tx_active  in  1  transmitter busy.
REQ-010 tx_byte  out  8  response byte; stable from tx_dv until tx_done.
REQ-011 tx_dv  out  1  one-cycle request to transmit tx_byte.
REQ-012 regs  out  NUM_REGS*8  flattened register file; register k occupies bits [8k+7:8k].
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 timeout  out  1  one-cycle pulse when a partial command is abandoned.
REQ-015 overrun  out  1  sticky flag: a byte arrived while the parser was not accepting input.

Function
REQ-016 The command set SHALL be:
- 'W'(8'h57) addr data: regs[addr]=data; respond 'K'(8'h4B).
- 'T'(8'h54) addr mask: regs[addr]^=mask; respond 'K'.
- 'R'(8'h52) addr: respond regs[addr].
- addr and data are raw binary bytes.
REQ-017 The FSM SHALL have the states IDLE, GET_ADDR, GET_DATA, EXECUTE, RESPOND and WAIT_TX.
REQ-018 In IDLE, rx_dv with a valid opcode SHALL latch the opcode and move to GET_ADDR.
REQ-019 In IDLE, rx_dv with any other byte SHALL load tx_byte='?'(8'h3F) and go to RESPOND.
REQ-020 In GET_ADDR, rx_dv SHALL latch addr, then go to GET_DATA for 'W'/'T' or to EXECUTE for 'R'.
REQ-021 In GET_DATA, rx_dv SHALL latch data and go to EXECUTE.
REQ-022 EXECUTE SHALL last exactly one cycle, update the register and load tx_byte, then go to RESPOND.
REQ-023 The register update SHALL be visible on regs the cycle after EXECUTE.
REQ-024 If addr >= NUM_REGS, EXECUTE SHALL leave all registers unchanged and load tx_byte='?'.
REQ-025 RESPOND SHALL wait until tx_active=0, then assert tx_dv for one cycle and go to WAIT_TX.
REQ-026 WAIT_TX SHALL hold tx_dv=0 and return to IDLE on tx_done.
REQ-027 Latency SHALL be: tx_dv asserts 2 cycles after the final command byte's rx_dv when tx_active=0 (the EXECUTE cycle, then the RESPOND cycle).
REQ-028 An inter-byte counter SHALL clear on each accepted rx_dv and increment every cycle in GET_ADDR and GET_DATA.
REQ-029 When the inter-byte counter reaches TIMEOUT_CYCLES-1, the FSM SHALL return to IDLE, pulse timeout and send no response.
REQ-030 If rx_dv coincides with the timeout cycle, the byte SHALL be accepted and no timeout SHALL occur.
REQ-031 rx_dv in EXECUTE, RESPOND or WAIT_TX SHALL drop the byte and set overrun; overrun clears only on rst.
REQ-032 Register writes SHALL occur only in EXECUTE, with at most one register changed per command.

Reset
REQ-033 On rst, the FSM SHALL enter IDLE immediately.
REQ-034 On rst, every register SHALL take RESET_VAL; tx_byte, tx_dv, timeout and overrun SHALL go to 0; busy SHALL go to 0.
REQ-035 On rst, the latched opcode, addr, data and inter-byte counter SHALL clear.
REQ-036 Reset mid-command or mid-transmit SHALL abort the command with no register change and no tx_dv.

Structure
REQ-037 A shared package SHALL hold the opcode constants ('W','T','R'), the 'K' and '?' response constants, and the state encoding.
REQ-038 The inter-byte timeout counter SHALL be a single sub-module named cmd_timeout with inputs clk, rst, clear, enable and the output expired.
REQ-039 The register file SHALL be implemented as flops, not inferred RAM.

Verification
REQ-040 Write: NUM_REGS=4, bytes 'W',8'h02,8'hA5 -> regs[23:16]=8'hA5, other registers 0, tx_byte='K' with one tx_dv.
REQ-041 Read after toggle: after REQ-040, bytes 'T',8'h02,8'h0F then 'R',8'h02 -> responses 'K' then 8'hAA.
REQ-042 Errors: byte 8'h41 -> '?'; bytes 'W',8'h04,8'h11 -> '?' with regs unchanged.
REQ-043 Timeout: TIMEOUT_CYCLES=16, 'W' then 16 idle cycles -> one timeout pulse, no tx_dv; then 'R',8'h00 -> 8'h00.
REQ-044 Back-pressure/overrun: hold tx_active=1 while sending 'R',8'h01 plus one extra byte -> tx_dv waits for tx_active=0, overrun=1, extra byte dropped.
REQ-045 Async reset: assert rst between 'W',8'h01 and the data byte -> FSM in IDLE, all registers equal RESET_VAL, no tx_dv.

Source files
------------

// File: rtl/reg_cmd_parser_pkg.sv
// -----------------------------------------------------------------------------
// reg_cmd_parser_pkg
// Shared constants and types for the byte-oriented register command parser:
// command opcodes, response bytes and the parser state encoding.
// -----------------------------------------------------------------------------
package reg_cmd_parser_pkg;

    // Command opcodes (ASCII)
    localparam logic [7:0] OP_WRITE  = 8'h57;  // 'W' addr data
    localparam logic [7:0] OP_TOGGLE = 8'h54;  // 'T' addr mask
    localparam logic [7:0] OP_READ   = 8'h52;  // 'R' addr

    // Response bytes (ASCII)
    localparam logic [7:0] RSP_OK    = 8'h4B;  // 'K'
    localparam logic [7:0] RSP_ERR   = 8'h3F;  // '?'

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
        EXECUTE,
        RESPOND,
        WAIT_TX
    } state_t;

    function automatic logic is_opcode(input logic [7:0] b);
        return (b == OP_WRITE) || (b == OP_TOGGLE) || (b == OP_READ);
    endfunction

endpackage

// File: rtl/reg_cmd_parser_timeout.sv
// -----------------------------------------------------------------------------
// cmd_timeout
// Inter-byte idle counter. Cleared whenever a byte is accepted, counts while
// enabled, and flags expiry on the cycle the count reaches TIMEOUT_CYCLES-1.
//
// Ports
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset
//   clear   : zero the count (takes priority over enable)
//   enable  : count this cycle (parser is waiting for a command byte)
//   expired : combinational, high while enabled and count == TIMEOUT_CYCLES-1
// -----------------------------------------------------------------------------
module cmd_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned    CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0]  LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;

    // NOTE: sequential state is always assigned with <= so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && (cnt != LAST)) begin
            // Saturate at LAST; the parser leaves the counting states on expiry.
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = enable && (cnt == LAST);

endmodule

// File: rtl/reg_cmd_parser.sv
// -----------------------------------------------------------------------------
// reg_cmd_parser
// Parses W/T/R commands from a byte stream into a small flop-based register
// file and emits a one-byte response per command.
//   'W' addr data : regs[addr] = data        -> 'K'
//   'T' addr mask : regs[addr] ^= mask       -> 'K'
//   'R' addr      :                          -> regs[addr]
//   bad opcode or addr >= NUM_REGS           -> '?'
//
// Ports
//   clk, rst  : clock (rising edge) and asynchronous active-high reset
//   rx_byte   : received byte, qualified by rx_dv (one-cycle strobe)
//   tx_done   : transmitter finished the current byte (one-cycle strobe)
//   tx_active : transmitter busy; response is held off while high
//   tx_byte   : response byte, stable from tx_dv until tx_done
//   tx_dv     : one-cycle transmit request
//   regs      : flattened register file, register k at [8k+7:8k]
//   busy      : parser not in IDLE
//   timeout   : one-cycle pulse when a partial command is abandoned
//   overrun   : sticky, a byte arrived while the parser could not take it
// -----------------------------------------------------------------------------
module reg_cmd_parser
    import reg_cmd_parser_pkg::*;
#(
    parameter int unsigned NUM_REGS       = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0]  RESET_VAL      = 8'h00
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_byte,
    input  logic                  rx_dv,
    input  logic                  tx_done,
    input  logic                  tx_active,
    output logic [7:0]            tx_byte,
    output logic                  tx_dv,
    output logic [NUM_REGS*8-1:0] regs,
    output logic                  busy,
    output logic                  timeout,
    output logic                  overrun
);

    state_t     state, next_state;
    logic [7:0] opcode_q, addr_q, data_q;
    logic [7:0] regs_q [NUM_REGS];

    logic       tmo_clear, tmo_enable, tmo_expired, tmo_fire;
    logic       addr_ok, do_write, drop_byte;
    logic [7:0] rd_val, wr_val, exec_rsp;

    // ---------------------------------------------------------------- timer
    cmd_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmo_clear),
        .enable  (tmo_enable),
        .expired (tmo_expired)
    );

    // ------------------------------------------------------------ FSM state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        next_state = state;
        tmo_clear  = 1'b0;
        tmo_enable = 1'b0;
        drop_byte  = 1'b0;
        case (state)
            IDLE: begin
                if (rx_dv) begin
                    tmo_clear  = 1'b1;
                    next_state = is_opcode(rx_byte) ? GET_ADDR : RESPOND;
                end
            end
            GET_ADDR: begin
                tmo_enable = 1'b1;
                // An accepted byte wins over a coincident expiry.
                if (rx_dv) begin
                    tmo_clear  = 1'b1;
                    next_state = (opcode_q == OP_READ) ? EXECUTE : GET_DATA;
                end else if (tmo_expired) begin
                    next_state = IDLE;
                end
            end
            GET_DATA: begin
                tmo_enable = 1'b1;
                if (rx_dv) begin
                    tmo_clear  = 1'b1;
                    next_state = EXECUTE;
                end else if (tmo_expired) begin
                    next_state = IDLE;
                end
            end
            EXECUTE: begin
                drop_byte  = rx_dv;
                next_state = RESPOND;
            end
            RESPOND: begin
                drop_byte = rx_dv;
                if (!tx_active) next_state = WAIT_TX;
            end
            WAIT_TX: begin
                drop_byte = rx_dv;
                if (tx_done) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign tmo_fire = tmo_expired && !rx_dv;
    assign tx_dv    = (state == RESPOND) && !tx_active;
    assign busy     = (state != IDLE);

    // ------------------------------------------------------ execute datapath
    // Widen to 9 bits so NUM_REGS = 256 compares correctly.
    assign addr_ok  = ({1'b0, addr_q} < 9'(NUM_REGS));
    assign do_write = (state == EXECUTE) && addr_ok && (opcode_q != OP_READ);

    always_comb begin
        rd_val = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (addr_q == 8'(k)) rd_val = regs_q[k];
        end
    end

    assign wr_val   = (opcode_q == OP_TOGGLE) ? (rd_val ^ data_q) : data_q;
    assign exec_rsp = !addr_ok                ? RSP_ERR :
                      (opcode_q == OP_READ)   ? rd_val  : RSP_OK;

    // ----------------------------------------------------------- register file
    // NOTE: the register file is a handful of flops, not a RAM, so it takes a
    // defined reset value like any other control state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= RESET_VAL;
        end else if (do_write) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (addr_q == 8'(k)) regs_q[k] <= wr_val;
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
        assign regs[8*g +: 8] = regs_q[g];
    end

    // -------------------------------------------------- command/response regs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opcode_q <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            tx_byte  <= '0;
            timeout  <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            timeout <= tmo_fire;
            if (drop_byte) overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (rx_dv) begin
                        if (is_opcode(rx_byte)) opcode_q <= rx_byte;
                        else                    tx_byte  <= RSP_ERR;
                    end
                end
                GET_ADDR: if (rx_dv) addr_q <= rx_byte;
                GET_DATA: if (rx_dv) data_q <= rx_byte;
                EXECUTE:  tx_byte <= exec_rsp;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_cmd_parser.sv
// -----------------------------------------------------------------------------
// tb_reg_cmd_parser
// Directed bench for reg_cmd_parser (NUM_REGS=4, TIMEOUT_CYCLES=16,
// RESET_VAL=0). Inputs change 1 time unit after a rising edge and outputs are
// sampled there too; a negedge monitor counts tx_dv and timeout pulses.
// -----------------------------------------------------------------------------
module tb_reg_cmd_parser;
    import reg_cmd_parser_pkg::*;

    localparam int unsigned NUM_REGS  = 4;
    localparam int unsigned TMO       = 16;
    localparam logic [7:0]  RESET_VAL = 8'h00;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [7:0]            rx_byte = 8'h00;
    logic                  rx_dv = 1'b0;
    logic                  tx_done = 1'b0;
    logic                  tx_active = 1'b0;
    logic [7:0]            tx_byte;
    logic                  tx_dv;
    logic [NUM_REGS*8-1:0] regs;
    logic                  busy;
    logic                  timeout;
    logic                  overrun;

    int checks = 0;
    int errors = 0;
    int tx_dv_cnt = 0;
    int timeout_cnt = 0;
    int tx_base, tmo_base;

    reg_cmd_parser #(
        .NUM_REGS       (NUM_REGS),
        .TIMEOUT_CYCLES (TMO),
        .RESET_VAL      (RESET_VAL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_byte   (rx_byte),
        .rx_dv     (rx_dv),
        .tx_done   (tx_done),
        .tx_active (tx_active),
        .tx_byte   (tx_byte),
        .tx_dv     (tx_dv),
        .regs      (regs),
        .busy      (busy),
        .timeout   (timeout),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_dv)   tx_dv_cnt   <= tx_dv_cnt + 1;
        if (timeout) timeout_cnt <= timeout_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_byte = b;
        rx_dv   = 1'b1;
        tick(1);
        rx_dv   = 1'b0;
    endtask

    // Waits (bounded) for tx_dv, checks the byte, the optional latency in
    // cycles after the call, the single-cycle strobe and return to IDLE.
    task automatic expect_resp(input string tag, input logic [7:0] exp, input int exp_lat);
        int lat = 0;
        while (!tx_dv && lat < 20) begin
            tick(1);
            lat++;
        end
        check({tag, " tx_dv seen"}, 32'(tx_dv), 32'h1);
        check({tag, " tx_byte"}, 32'(tx_byte), 32'(exp));
        if (exp_lat >= 0) check({tag, " latency"}, lat, exp_lat);
        tick(1);
        check({tag, " tx_dv one cycle"}, 32'(tx_dv), 32'h0);
        check({tag, " tx_byte held"}, 32'(tx_byte), 32'(exp));
        tx_done = 1'b1;
        tick(1);
        tx_done = 1'b0;
        check({tag, " idle after tx_done"}, 32'(busy), 32'h0);
    endtask

    initial begin
        // ---------------- reset state
        tick(3);
        rst = 1'b0;
        tick(1);
        check("reset regs", regs, 32'h0000_0000);
        check("reset busy", 32'(busy), 32'h0);
        check("reset tx_dv", 32'(tx_dv), 32'h0);
        check("reset tx_byte", 32'(tx_byte), 32'h0);
        check("reset timeout", 32'(timeout), 32'h0);
        check("reset overrun", 32'(overrun), 32'h0);

        // ---------------- write W 02 A5
        tx_base = tx_dv_cnt;
        send(OP_WRITE); send(8'h02); send(8'hA5);
        expect_resp("write", RSP_OK, 1);
        check("write regs", regs, 32'h00A5_0000);
        check("write one tx_dv", tx_dv_cnt - tx_base, 1);

        // ---------------- toggle T 02 0F, then read R 02
        send(OP_TOGGLE); send(8'h02); send(8'h0F);
        expect_resp("toggle", RSP_OK, 1);
        check("toggle regs", regs, 32'h00AA_0000);
        send(OP_READ); send(8'h02);
        expect_resp("read", 8'hAA, 1);
        check("read regs unchanged", regs, 32'h00AA_0000);

        // ---------------- errors
        send(8'h41);
        expect_resp("bad opcode", RSP_ERR, 0);
        send(OP_WRITE); send(8'h04); send(8'h11);
        expect_resp("bad addr", RSP_ERR, 1);
        check("bad addr regs", regs, 32'h00AA_0000);

        // ---------------- timeout after 'W' and 16 idle cycles
        tx_base  = tx_dv_cnt;
        tmo_base = timeout_cnt;
        send(OP_WRITE);
        tick(15);
        check("tmo busy before", 32'(busy), 32'h1);
        check("tmo not yet", 32'(timeout), 32'h0);
        tick(1);
        check("tmo pulse", 32'(timeout), 32'h1);
        check("tmo back to idle", 32'(busy), 32'h0);
        tick(1);
        check("tmo pulse ends", 32'(timeout), 32'h0);
        tick(3);
        check("tmo pulse count", timeout_cnt - tmo_base, 1);
        check("tmo no tx_dv", tx_dv_cnt - tx_base, 0);
        send(OP_READ); send(8'h00);
        expect_resp("read after tmo", 8'h00, 1);

        // ---------------- byte on the expiry cycle is accepted
        tmo_base = timeout_cnt;
        send(OP_WRITE);
        tick(15);
        send(8'h01);
        check("edge byte accepted", 32'(busy), 32'h1);
        send(8'h3C);
        expect_resp("edge write", RSP_OK, 1);
        check("edge regs", regs, 32'h00AA_3C00);
        check("edge no timeout", timeout_cnt - tmo_base, 0);

        // ---------------- back-pressure and overrun
        tx_active = 1'b1;
        send(OP_READ); send(8'h01);
        send(OP_WRITE);  // extra byte during EXECUTE
        check("overrun set", 32'(overrun), 32'h1);
        tick(3);
        check("held off tx_dv", 32'(tx_dv), 32'h0);
        check("held off busy", 32'(busy), 32'h1);
        tx_active = 1'b0;
        #1;
        expect_resp("backpressure read", 8'h3C, 0);
        check("overrun sticky", 32'(overrun), 32'h1);
        check("extra byte dropped regs", regs, 32'h00AA_3C00);

        // ---------------- async reset mid-command
        send(OP_WRITE); send(8'h01);
        check("mid-cmd busy", 32'(busy), 32'h1);
        tx_base = tx_dv_cnt;
        rst = 1'b1;
        #1;
        check("async rst idle", 32'(busy), 32'h0);
        check("async rst regs", regs, 32'h0000_0000);
        check("async rst overrun", 32'(overrun), 32'h0);
        tick(2);
        rst = 1'b0;
        tick(5);
        check("post rst no tx_dv", tx_dv_cnt - tx_base, 0);
        check("post rst regs", regs, 32'h0000_0000);
        send(OP_READ); send(8'h01);
        expect_resp("read after rst", RESET_VAL, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
